lcd_write_arbiter: RTL and testbench

- Owns the HD44780 character-LCD write bus.
- After reset it issues the fixed 5-command power-on init sequence.
- It then shares the bus between two client requesters, each supplying one 9-bit {RS,DATA} word per request, using round-robin arbitration.
- It generates the RS/DATA setup, the EN pulse width and the post-write execution delay, so clients never handle LCD timing.

---
 rtl/lcd_write_arbiter.sv | 157 +++++++++++++++
 tb/tb_lcd_write_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_write_arbiter.sv
// HD44780 write-bus owner: runs the power-on init sequence, then round-robin
// shares the bus between two clients while generating setup, EN and exec delays.
module lcd_write_arbiter #(
  parameter int EN_HIGH_CYC    = 24,
  parameter int LONG_WAIT_CYC  = 82433,
  parameter int SHORT_WAIT_CYC = 2500,
  parameter int PAYLOAD_BITS   = 8
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic                    REQ0_I,
  input  logic [PAYLOAD_BITS:0]   DATA0_I,
  output logic                    ACK0_O,
  input  logic                    REQ1_I,
  input  logic [PAYLOAD_BITS:0]   DATA1_I,
  output logic                    ACK1_O,
  output logic                    INIT_DONE_O,
  output logic                    BUSY_O,
  output logic [PAYLOAD_BITS-1:0] LCD_DATA_O,
  output logic                    LCD_RS_O,
  output logic                    LCD_RW_O,
  output logic                    LCD_EN_O
);

  localparam int MAX_AB  = (EN_HIGH_CYC > LONG_WAIT_CYC) ? EN_HIGH_CYC : LONG_WAIT_CYC;
  localparam int MAX_CYC = (MAX_AB > SHORT_WAIT_CYC) ? MAX_AB : SHORT_WAIT_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int WORD_W  = PAYLOAD_BITS + 1;

  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(SHORT_WAIT_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, EN_HIGH, HOLD} state_t;

  state_t             state_reg, state_next;
  logic [2:0]         init_idx_reg, init_idx_next;
  logic               rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [WORD_W-1:0]  word_reg, word_next;
  logic               en_reg, en_next;
  logic               ack0_reg, ack0_next;
  logic               ack1_reg, ack1_next;
  logic               init_done_reg, init_done_next;

  logic [WORD_W-1:0]  init_word;
  logic               is_long;
  logic [CNT_W-1:0]   wait_last;
  logic               grant1;

  always_comb begin
    init_word = '0;
    case (init_idx_reg)
      3'd0:    init_word = WORD_W'(9'h038);
      3'd1:    init_word = WORD_W'(9'h00C);
      3'd2:    init_word = WORD_W'(9'h001);
      3'd3:    init_word = WORD_W'(9'h006);
      3'd4:    init_word = WORD_W'(9'h080);
      default: init_word = '0;
    endcase
  end

  // Clear and Home (RS=0, 0x01..0x03) need the long execution time
  assign is_long = !word_reg[PAYLOAD_BITS] &&
                   (word_reg[PAYLOAD_BITS-1:0] != '0) &&
                   (word_reg[PAYLOAD_BITS-1:0] <= PAYLOAD_BITS'(3));
  assign wait_last = is_long ? LONG_LAST : SHORT_LAST;

  always_comb begin
    state_next     = state_reg;
    init_idx_next  = init_idx_reg;
    rr_ptr_next    = rr_ptr_reg;
    cnt_next       = cnt_reg;
    word_next      = word_reg;
    en_next        = en_reg;
    ack0_next      = 1'b0;
    ack1_next      = 1'b0;
    init_done_next = init_done_reg;
    grant1         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!init_done_reg) begin
          word_next  = init_word;
          state_next = SETUP;
        end else if (REQ0_I || REQ1_I) begin
          grant1      = (REQ0_I && REQ1_I) ? rr_ptr_reg : REQ1_I;
          rr_ptr_next = !grant1;
          word_next   = grant1 ? DATA1_I : DATA0_I;
          ack0_next   = !grant1;
          ack1_next   = grant1;
          state_next  = SETUP;
        end
      end
      SETUP: begin
        en_next    = 1'b1;
        cnt_next   = '0;
        state_next = EN_HIGH;
      end
      EN_HIGH: begin
        if (cnt_reg == EN_LAST) begin
          en_next    = 1'b0;
          cnt_next   = '0;
          state_next = HOLD;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_reg == wait_last) begin
          cnt_next   = '0;
          state_next = IDLE;
          if (!init_done_reg) begin
            init_idx_next = init_idx_reg + 3'd1;
            if (init_idx_reg == 3'd4) init_done_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_reg     <= IDLE;
      init_idx_reg  <= '0;
      rr_ptr_reg    <= 1'b0;
      cnt_reg       <= '0;
      word_reg      <= '0;
      en_reg        <= 1'b0;
      ack0_reg      <= 1'b0;
      ack1_reg      <= 1'b0;
      init_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      init_idx_reg  <= init_idx_next;
      rr_ptr_reg    <= rr_ptr_next;
      cnt_reg       <= cnt_next;
      word_reg      <= word_next;
      en_reg        <= en_next;
      ack0_reg      <= ack0_next;
      ack1_reg      <= ack1_next;
      init_done_reg <= init_done_next;
    end
  end

  assign ACK0_O      = ack0_reg;
  assign ACK1_O      = ack1_reg;
  assign INIT_DONE_O = init_done_reg;
  assign BUSY_O      = !((state_reg == IDLE) && init_done_reg);
  assign LCD_DATA_O  = word_reg[PAYLOAD_BITS-1:0];
  assign LCD_RS_O    = word_reg[PAYLOAD_BITS];
  assign LCD_RW_O    = 1'b0;
  assign LCD_EN_O    = en_reg;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Randomized bench for lcd_write_arbiter: a bus monitor compares every LCD write,
// EN width, execution wait and client grant against a transaction-level model.
module tb_lcd_write_arbiter;

  localparam int EN_CYC = 4;
  localparam int LONG_W = 20;
  localparam int SHORT_W = 8;

  logic clk = 1'b0;
  logic rst;
  logic req0, req1;
  logic [8:0] d0, d1;
  logic ack0, ack1, init_done, busy;
  logic [7:0] lcd_data;
  logic lcd_rs, lcd_rw, lcd_en;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lcd_write_arbiter #(
    .EN_HIGH_CYC(EN_CYC), .LONG_WAIT_CYC(LONG_W), .SHORT_WAIT_CYC(SHORT_W), .PAYLOAD_BITS(8)
  ) dut (
    .CLK_I(clk), .RST_I(rst),
    .REQ0_I(req0), .DATA0_I(d0), .ACK0_O(ack0),
    .REQ1_I(req1), .DATA1_I(d1), .ACK1_O(ack1),
    .INIT_DONE_O(init_done), .BUSY_O(busy),
    .LCD_DATA_O(lcd_data), .LCD_RS_O(lcd_rs), .LCD_RW_O(lcd_rw), .LCD_EN_O(lcd_en)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wait_of(input logic [8:0] w);
    return (!w[8] && w[7:0] >= 8'd1 && w[7:0] <= 8'd3) ? LONG_W : SHORT_W;
  endfunction

  // Transaction-level reference: expected words, grants and timing
  logic [8:0] init_tab [5] = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080};
  logic [8:0] exp_q [$];
  logic [8:0] cur_word, exp_w;
  bit en_prev, ack_prev, in_hold, cur_init, last_win, exp_win, done_prev, rise;
  bit p_req0, p_req1;
  int en_cnt, hold_cnt, init_cnt;

  always @(negedge clk) begin
    if (rst) begin
      en_prev = 0; ack_prev = 0; in_hold = 0; cur_init = 0; last_win = 1;
      done_prev = 0; p_req0 = 0; p_req1 = 0;
      en_cnt = 0; hold_cnt = 0; init_cnt = 0;
      exp_q.delete();
    end else begin
      if (ack0 || ack1) begin
        check("ack_onehot", int'(ack0 && ack1), 0);
        check("ack_after_init", int'(init_done), 1);
        check("ack_had_req", int'(p_req0 || p_req1), 1);
        exp_win = (p_req0 && p_req1) ? !last_win : p_req1;
        check("ack_winner", int'(ack1), int'(exp_win));
        check("ack_one_cycle", int'(ack_prev), 0);
        last_win = ack1;
        exp_q.push_back(ack1 ? d1 : d0);
        $display("grant client=%0d word=0x%03h t=%0t", ack1, ack1 ? d1 : d0, $time);
      end
      if (init_done && !done_prev) check("busy_at_init_done", int'(busy), 0);
      rise = lcd_en && !en_prev;
      if (in_hold) begin
        if (cur_init && init_cnt < 5) begin
          if (rise) begin
            check("init_gap", hold_cnt, wait_of(cur_word) + 2);
            in_hold = 0;
          end else hold_cnt++;
        end else if (cur_init) begin
          if (init_done) begin
            check("last_init_wait", hold_cnt, wait_of(cur_word));
            in_hold = 0;
          end else hold_cnt++;
        end else begin
          if (!busy) begin
            check("client_wait", hold_cnt, wait_of(cur_word));
            in_hold = 0;
          end else hold_cnt++;
        end
      end
      if (rise) begin
        exp_w = '0;
        if (!init_done) begin
          if (init_cnt < 5) exp_w = init_tab[init_cnt];
          check("init_overrun", init_cnt < 5 ? 0 : 1, 0);
          cur_init = 1;
          init_cnt++;
        end else begin
          check("word_expected", exp_q.size() > 0 ? 1 : 0, 1);
          if (exp_q.size() > 0) exp_w = exp_q.pop_front();
          cur_init = 0;
        end
        check("lcd_word", int'({lcd_rs, lcd_data}), int'(exp_w));
        check("lcd_rw", int'(lcd_rw), 0);
        $display("write word=0x%03h init=%0d t=%0t", {lcd_rs, lcd_data}, cur_init, $time);
        cur_word = exp_w;
        en_cnt = 0;
      end
      if (lcd_en && !rise) check("bus_stable", int'({lcd_rs, lcd_data}), int'(cur_word));
      if (lcd_en) en_cnt++;
      if (!lcd_en && en_prev) begin
        check("en_width", en_cnt, EN_CYC);
        in_hold = 1;
        hold_cnt = 1;
      end
      en_prev = lcd_en; ack_prev = ack0 || ack1;
      p_req0 = req0; p_req1 = req1; done_prev = init_done;
    end
  end

  task automatic send(input int c, input logic [8:0] w);
    int n;
    bit got;
    n = 0; got = 0;
    if (c == 0) begin req0 = 1; d0 = w; end else begin req1 = 1; d1 = w; end
    while (!got && n < 3000) begin
      @(negedge clk);
      n++;
      got = (c == 0) ? ack0 : ack1;
    end
    if (!got) check("ack_timeout", 0, 1);
    @(posedge clk); #1;
    if (c == 0) req0 = 0; else req1 = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 1000);
    if (busy) check("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic client_rand(input int c, input int cnt);
    int g;
    logic [8:0] w;
    for (int i = 0; i < cnt; i++) begin
      g = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) w = {1'b0, 8'($urandom_range(1, 3))};
      else w = 9'($urandom_range(0, 511));
      if (g > 0) begin repeat (g) @(posedge clk); #1; end
      send(c, w);
    end
  endtask

  initial begin
    int n;
    rst = 1; req0 = 0; req1 = 0; d0 = '0; d1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_en", int'(lcd_en), 0);
    check("rst_rs", int'(lcd_rs), 0);
    check("rst_data", int'(lcd_data), 0);
    check("rst_ack", int'({ack1, ack0}), 0);
    check("rst_init_done", int'(init_done), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_rw", int'(lcd_rw), 0);
    @(posedge clk); #1;
    rst = 0;

    send(0, 9'h141);
    check("init_done_before_ack", int'(init_done), 1);
    fork
      begin for (int i = 0; i < 4; i++) send(0, 9'h130); end
      begin for (int i = 0; i < 4; i++) send(1, 9'h131); end
    join
    wait_idle();
    send(1, 9'h001);
    wait_idle();
    send(1, 9'h101);
    wait_idle();
    fork
      send(0, 9'h1A0);
      send(1, 9'h1A1);
    join
    wait_idle();

    fork
      client_rand(0, 15);
      client_rand(1, 15);
    join
    wait_idle();

    // reset while EN is high on a client word
    req1 = 1; d1 = 9'h155;
    n = 0;
    do begin @(negedge clk); n++; end while (!(lcd_en && init_done) && n < 500);
    check("en_seen_before_reset", int'(lcd_en && init_done), 1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_en", int'(lcd_en), 0);
    check("mid_rst_init_done", int'(init_done), 0);
    check("mid_rst_ack", int'({ack1, ack0}), 0);
    check("mid_rst_data", int'({lcd_rs, lcd_data}), 0);
    @(posedge clk); #1;
    rst = 0;
    send(1, 9'h155);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
